// File: rtl/jhash_pkg.sv
// Shared types and defaults for the Jenkins-hash key feeder: FSM states,
// size defaults and the 64-bit key word type.
package jhash_pkg;

    localparam int MAX_WORDS_DEF = 64;
    localparam int LEN_W_DEF     = 8;

    typedef logic [63:0] word_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_STREAM,
        ST_WAIT,
        ST_RESULT
    } state_t;

endpackage

// File: rtl/jhash_byte_packer.sv
// Packs key bytes little-endian into 64-bit words. Every accepted byte rewrites
// the whole current word, so bytes not yet received always read back as zero.
module jhash_byte_packer
    import jhash_pkg::*;
#(
    parameter int MAX_WORDS = MAX_WORDS_DEF,
    parameter int LEN_W     = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             byte_vld_i,
    input  logic [7:0]       byte_i,
    output logic             wr_en_o,
    output logic [LEN_W-1:0] wr_idx_o,
    output word_t            wr_word_o,
    output logic [LEN_W-1:0] nwords_o,
    output logic             ovf_o
);

    logic [2:0]       pos_q, pos_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic             ovf_q, ovf_d;
    word_t            acc_q;
    logic             full;

    assign full     = (idx_q == LEN_W'(MAX_WORDS));
    assign wr_en_o  = byte_vld_i && !full;
    assign wr_idx_o = idx_q;

    // nwords_o and ovf_o already include the byte presented this cycle
    always_comb begin
        wr_word_o = (pos_q == 3'd0) ? '0 : acc_q;
        wr_word_o[{pos_q, 3'b000} +: 8] = byte_i;
        pos_d = pos_q;
        idx_d = idx_q;
        ovf_d = ovf_q;
        if (byte_vld_i) begin
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                pos_d = pos_q + 3'd1;
                if (pos_q == 3'd7) begin
                    idx_d = idx_q + LEN_W'(1);
                end
            end
        end
        nwords_o = idx_d + LEN_W'(pos_d != 3'd0);
        ovf_o    = ovf_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q <= 3'd0;
            idx_q <= '0;
            ovf_q <= 1'b0;
        end else if (clr_i) begin
            pos_q <= 3'd0;
            idx_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            pos_q <= pos_d;
            idx_q <= idx_d;
            ovf_q <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_o) begin
            acc_q <= wr_word_o;
        end
    end

endmodule

// File: rtl/jhash_key_feeder.sv
// Buffers a byte-streamed key, replays it as 64-bit words to a hash core on
// consecutive cycles, then holds the core's result until it is taken.
module jhash_key_feeder
    import jhash_pkg::*;
#(
    parameter int MAX_WORDS = MAX_WORDS_DEF,
    parameter int LEN_W     = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             s_last,
    output logic             h_ce,
    output logic [63:0]      h_id,
    output logic             h_last,
    output logic [LEN_W-1:0] h_len,
    input  logic             h_done,
    input  logic [31:0]      h_dout,
    output logic [31:0]      m_hash,
    output logic [LEN_W-1:0] m_words,
    output logic             m_ovf,
    output logic             m_valid,
    input  logic             m_ready
);

    localparam int IDX_W = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

    state_t           state_q;
    word_t            buf_q [MAX_WORDS];
    logic [LEN_W-1:0] rd_q;
    logic             h_ce_q, h_last_q, m_ovf_q, m_valid_q;
    word_t            h_id_q;
    logic [LEN_W-1:0] h_len_q, m_words_q;
    logic [31:0]      m_hash_q;

    logic             accept;
    logic             wr_en;
    logic [LEN_W-1:0] wr_idx;
    word_t            wr_word;
    logic [LEN_W-1:0] nwords;
    logic             ovf;
    word_t            word0;

    assign s_ready = (state_q == ST_IDLE) || (state_q == ST_FILL);
    assign accept  = s_valid && s_ready;

    jhash_byte_packer #(
        .MAX_WORDS (MAX_WORDS),
        .LEN_W     (LEN_W)
    ) u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (state_q == ST_STREAM),
        .byte_vld_i (accept),
        .byte_i     (s_data),
        .wr_en_o    (wr_en),
        .wr_idx_o   (wr_idx),
        .wr_word_o  (wr_word),
        .nwords_o   (nwords),
        .ovf_o      (ovf)
    );

    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_q[wr_idx[IDX_W-1:0]] <= wr_word;
        end
    end

    // Word 0 may be written by the very s_last byte, so bypass the buffer
    assign word0 = (wr_en && wr_idx == '0) ? wr_word : buf_q[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rd_q      <= '0;
            h_ce_q    <= 1'b0;
            h_id_q    <= '0;
            h_last_q  <= 1'b0;
            h_len_q   <= '0;
            m_hash_q  <= '0;
            m_words_q <= '0;
            m_ovf_q   <= 1'b0;
            m_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_FILL: begin
                    if (accept) begin
                        if (s_last) begin
                            state_q  <= ST_STREAM;
                            h_ce_q   <= 1'b1;
                            h_id_q   <= word0;
                            h_last_q <= (nwords == LEN_W'(1));
                            h_len_q  <= nwords;
                            m_ovf_q  <= ovf;
                            rd_q     <= LEN_W'(1);
                        end else begin
                            state_q <= ST_FILL;
                        end
                    end
                end
                ST_STREAM: begin
                    if (h_last_q) begin
                        state_q  <= ST_WAIT;
                        h_ce_q   <= 1'b0;
                        h_last_q <= 1'b0;
                        h_id_q   <= '0;
                    end else begin
                        h_id_q   <= buf_q[rd_q[IDX_W-1:0]];
                        h_last_q <= (rd_q == h_len_q - LEN_W'(1));
                        rd_q     <= rd_q + LEN_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (h_done) begin
                        state_q   <= ST_RESULT;
                        m_hash_q  <= h_dout;
                        m_words_q <= h_len_q;
                        m_valid_q <= 1'b1;
                    end
                end
                ST_RESULT: begin
                    if (m_ready) begin
                        state_q   <= ST_IDLE;
                        m_valid_q <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign h_ce    = h_ce_q;
    assign h_id    = h_id_q;
    assign h_last  = h_last_q;
    assign h_len   = h_len_q;
    assign m_hash  = m_hash_q;
    assign m_words = m_words_q;
    assign m_ovf   = m_ovf_q;
    assign m_valid = m_valid_q;

endmodule

// File: tb/tb_jhash_key_feeder.sv
// Directed bench for jhash_key_feeder; the bench itself stands in for the hash
// core and the result consumer.
module tb_jhash_key_feeder;

    localparam int MAX_WORDS = 64;
    localparam int LEN_W     = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [7:0]       s_data = '0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic             s_last = 1'b0;
    logic             h_ce;
    logic [63:0]      h_id;
    logic             h_last;
    logic [LEN_W-1:0] h_len;
    logic             h_done = 1'b0;
    logic [31:0]      h_dout = '0;
    logic [31:0]      m_hash;
    logic [LEN_W-1:0] m_words;
    logic             m_ovf;
    logic             m_valid;
    logic             m_ready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]       key_mem [0:1023];
    logic [63:0]      got_id  [0:127];
    logic             got_last[0:127];
    int               got_n;
    logic [LEN_W-1:0] got_len;
    logic             len_stable;
    logic             first_ok;
    logic             sready_low;

    always #5 clk = ~clk;

    jhash_key_feeder #(
        .MAX_WORDS (MAX_WORDS),
        .LEN_W     (LEN_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_last  (s_last),
        .h_ce    (h_ce),
        .h_id    (h_id),
        .h_last  (h_last),
        .h_len   (h_len),
        .h_done  (h_done),
        .h_dout  (h_dout),
        .m_hash  (m_hash),
        .m_words (m_words),
        .m_ovf   (m_ovf),
        .m_valid (m_valid),
        .m_ready (m_ready)
    );

    // Reference packing: little-endian, zero beyond the key end
    function automatic logic [63:0] model_word(int w, int nbytes);
        logic [63:0] r;
        r = '0;
        for (int b = 0; b < 8; b++)
            if (w * 8 + b < nbytes) r[8*b +: 8] = key_mem[w*8+b];
        return r;
    endfunction

    task automatic send_key(input int nbytes);
        for (int k = 0; k < nbytes; k++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = key_mem[k];
            s_last  = (k == nbytes - 1);
            @(posedge clk);
        end
    endtask

    task automatic collect(input int max_cycles);
        got_n      = 0;
        len_stable = 1'b1;
        sready_low = 1'b1;
        got_len    = '0;
        @(negedge clk);
        s_valid  = 1'b0;
        s_last   = 1'b0;
        first_ok = (h_ce === 1'b1);
        for (int c = 0; c < max_cycles; c++) begin
            if (c > 0) @(negedge clk);
            if (s_ready !== 1'b0) sready_low = 1'b0;
            if (h_ce === 1'b1) begin
                if (got_n == 0) got_len = h_len;
                else if (h_len !== got_len) len_stable = 1'b0;
                got_id[got_n]   = h_id;
                got_last[got_n] = h_last;
                got_n++;
            end else if (got_n > 0) begin
                break;
            end
        end
    endtask

    task automatic core_done(input logic [31:0] v);
        @(negedge clk);
        h_done = 1'b1;
        h_dout = v;
        @(negedge clk);
        h_done = 1'b0;
        h_dout = '0;
    endtask

    task automatic ack_result();
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({h_ce, h_id, h_last, h_len, m_valid, m_hash, m_words, m_ovf} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ce=%b id=%h last=%b len=%0d mv=%b hash=%h words=%0d ovf=%b, required all zero",
                     h_ce, h_id, h_last, h_len, m_valid, m_hash, m_words, m_ovf);
        end
        n_checks++;
        if (s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_s_ready: got %b required 1", s_ready);
        end
        rst_n = 1'b1;
        core_done(32'hCAFEF00D);
        repeat (2) @(negedge clk);
        n_checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_h_done_ignored: got m_valid=%b s_ready=%b required 0/1", m_valid, s_ready);
        end
    endtask

    task automatic test_short_key();
        logic [95:0] txt;
        txt = "aaaabbbbcccc";
        for (int k = 0; k < 12; k++) key_mem[k] = txt[8*(11-k) +: 8];
        send_key(12);
        collect(10);
        n_checks++;
        if (got_n !== 2 || got_len !== 8'd2 || !first_ok || !len_stable || !sready_low) begin
            n_fail++;
            $display("FAIL short_shape: got words=%0d len=%0d first=%b stable=%b sready_low=%b required 2/2/1/1/1",
                     got_n, got_len, first_ok, len_stable, sready_low);
        end
        n_checks++;
        if (got_id[0] !== 64'h62626262_61616161 || got_id[1] !== 64'h00000000_63636363) begin
            n_fail++;
            $display("FAIL short_words: got %h %h required 6262626261616161 0000000063636363", got_id[0], got_id[1]);
        end
        n_checks++;
        if (got_last[0] !== 1'b0 || got_last[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL short_last: got %b%b required 01", got_last[0], got_last[1]);
        end
        core_done(32'haae2d3d1);
        n_checks++;
        if (m_valid !== 1'b1 || m_hash !== 32'haae2d3d1 || m_words !== 8'd2 || m_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL short_result: got mv=%b hash=%h words=%0d ovf=%b required 1/aae2d3d1/2/0",
                     m_valid, m_hash, m_words, m_ovf);
        end
        ack_result();
        n_checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL short_ack: got m_valid=%b s_ready=%b required 0/1", m_valid, s_ready);
        end
    endtask

    task automatic test_single_byte();
        key_mem[0] = 8'h5A;
        send_key(1);
        collect(6);
        n_checks++;
        if (got_n !== 1 || got_len !== 8'd1 || !first_ok || got_id[0] !== 64'h5A || got_last[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL single_stream: got words=%0d len=%0d first=%b id=%h last=%b required 1/1/1/5a/1",
                     got_n, got_len, first_ok, got_id[0], got_last[0]);
        end
        core_done(32'h0000_1111);
        n_checks++;
        if (m_valid !== 1'b1 || m_words !== 8'd1 || m_hash !== 32'h0000_1111) begin
            n_fail++;
            $display("FAIL single_result: got mv=%b words=%0d hash=%h required 1/1/00001111", m_valid, m_words, m_hash);
        end
        ack_result();
    endtask

    task automatic test_full_512();
        for (int k = 0; k < 512; k++) key_mem[k] = 8'(k);
        send_key(512);
        collect(80);
        n_checks++;
        if (got_n !== 64 || got_len !== 8'd64 || !first_ok || !len_stable) begin
            n_fail++;
            $display("FAIL full_shape: got words=%0d len=%0d first=%b stable=%b required 64/64/1/1",
                     got_n, got_len, first_ok, len_stable);
        end
        n_checks++;
        if (got_id[0] !== 64'h07060504_03020100 || got_id[63] !== 64'hfffefdfc_fbfaf9f8) begin
            n_fail++;
            $display("FAIL full_ends: got %h %h required 0706050403020100 fffefdfcfbfaf9f8", got_id[0], got_id[63]);
        end
        for (int w = 0; w < 64; w++) begin
            n_checks++;
            if (got_id[w] !== model_word(w, 512) || got_last[w] !== (w == 63)) begin
                n_fail++;
                $display("FAIL full_word%0d: got %h last=%b required %h last=%b",
                         w, got_id[w], got_last[w], model_word(w, 512), (w == 63));
            end
        end
        core_done(32'hb79375ae);
        n_checks++;
        if (m_valid !== 1'b1 || m_hash !== 32'hb79375ae || m_words !== 8'd64 || m_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL full_result: got mv=%b hash=%h words=%0d ovf=%b required 1/b79375ae/64/0",
                     m_valid, m_hash, m_words, m_ovf);
        end
        ack_result();
    endtask

    task automatic test_overflow_513();
        for (int k = 0; k < 512; k++) key_mem[k] = 8'(k);
        key_mem[512] = 8'hEE;
        send_key(513);
        collect(80);
        n_checks++;
        if (got_n !== 64 || got_len !== 8'd64 || got_last[63] !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_shape: got words=%0d len=%0d last63=%b required 64/64/1", got_n, got_len, got_last[63]);
        end
        n_checks++;
        if (got_id[0] !== 64'h07060504_03020100 || got_id[63] !== model_word(63, 512)) begin
            n_fail++;
            $display("FAIL ovf_words: got %h %h required 0706050403020100 %h", got_id[0], got_id[63], model_word(63, 512));
        end
        core_done(32'h5555_AAAA);
        n_checks++;
        if (m_valid !== 1'b1 || m_ovf !== 1'b1 || m_words !== 8'd64) begin
            n_fail++;
            $display("FAIL ovf_result: got mv=%b ovf=%b words=%0d required 1/1/64", m_valid, m_ovf, m_words);
        end
        ack_result();
    endtask

    task automatic test_result_hold();
        key_mem[0] = 8'h01; key_mem[1] = 8'h02; key_mem[2] = 8'h03;
        send_key(3);
        collect(6);
        n_checks++;
        if (got_n !== 1 || got_id[0] !== 64'h030201 || got_last[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_stream: got words=%0d id=%h last=%b required 1/030201/1", got_n, got_id[0], got_last[0]);
        end
        core_done(32'h1234_5678);
        s_valid = 1'b1; s_data = 8'h77; s_last = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c == 3) begin h_done = 1'b1; h_dout = 32'hDEADBEEF; end
            else        begin h_done = 1'b0; h_dout = '0; end
            @(negedge clk);
            n_checks++;
            if (m_valid !== 1'b1 || m_hash !== 32'h1234_5678 || s_ready !== 1'b0 || m_words !== 8'd1 || m_ovf !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: got mv=%b hash=%h s_ready=%b words=%0d ovf=%b required 1/12345678/0/1/0",
                         c, m_valid, m_hash, s_ready, m_words, m_ovf);
            end
        end
        s_valid = 1'b0; s_last = 1'b0;
        ack_result();
        repeat (2) @(negedge clk);
        n_checks++;
        if (m_valid !== 1'b0 || h_ce !== 1'b0 || s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_after_ack: got mv=%b h_ce=%b s_ready=%b required 0/0/1", m_valid, h_ce, s_ready);
        end
    endtask

    task automatic test_reset_mid_stream();
        int seen;
        for (int k = 0; k < 64; k++) key_mem[k] = 8'(k * 3 + 1);
        send_key(64);
        seen = 0;
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) @(negedge clk);
            if (h_ce === 1'b1) seen++;
            if (seen == 6) break;
        end
        n_checks++;
        if (seen != 6 || h_id !== model_word(5, 64)) begin
            n_fail++;
            $display("FAIL abort_reach_word5: got seen=%0d id=%h required 6/%h", seen, h_id, model_word(5, 64));
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (h_ce !== 1'b0 || h_last !== 1'b0 || m_valid !== 1'b0 || s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_immediate: got h_ce=%b h_last=%b mv=%b s_ready=%b required 0/0/0/1",
                     h_ce, h_last, m_valid, s_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        core_done(32'h0BAD_0BAD);
        repeat (3) @(negedge clk);
        n_checks++;
        if (m_valid !== 1'b0 || h_ce !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_result: got mv=%b h_ce=%b required 0/0", m_valid, h_ce);
        end
        for (int k = 0; k < 9; k++) key_mem[k] = 8'hA0 + 8'(k);
        send_key(9);
        collect(6);
        n_checks++;
        if (got_n !== 2 || got_id[0] !== 64'hA7A6A5A4_A3A2A1A0 || got_id[1] !== 64'h00000000_000000A8 || got_last[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_next_key: got words=%0d %h %h last=%b required 2 a7a6a5a4a3a2a1a0 00000000000000a8 1",
                     got_n, got_id[0], got_id[1], got_last[1]);
        end
        core_done(32'h0000_0009);
        n_checks++;
        if (m_valid !== 1'b1 || m_words !== 8'd2 || m_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_next_result: got mv=%b words=%0d ovf=%b required 1/2/0", m_valid, m_words, m_ovf);
        end
        ack_result();
    endtask

    initial begin
        test_reset();
        test_short_key();
        test_single_byte();
        test_full_512();
        test_overflow_513();
        test_result_hold();
        test_reset_mid_stream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/jhash_key_feeder.md
JHASH_KEY_FEEDER -- requirements
Module: jhash_key_feeder

Interface
REQ-001 Parameter MAX_WORDS, default 64, maximum key length in 64-bit words.
REQ-002 Parameter LEN_W, default 8, width of word-count fields; SHALL satisfy 2^LEN_W > MAX_WORDS.
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 s_data  in  8  key byte.
REQ-006 s_valid / s_ready  in / out  1 / 1  byte handshake; a byte is accepted when both are high.
REQ-007 s_last  in  1  marks the final byte of a key.
REQ-008 h_ce  out  1  word strobe to the hash core; the core consumes h_id in every cycle in which h_ce is high.
REQ-009 h_id  out  64  key word, little-endian packed.
REQ-010 h_last  out  1  final-word flag, qualified by h_ce.
REQ-011 h_len  out  LEN_W  key length in words, held constant from the first h_ce until h_done.
REQ-012 h_done / h_dout  in / in  1 / 32  single-cycle completion pulse and hash value from the core.
REQ-013 m_hash / m_words / m_ovf  out  32 / LEN_W / 1  result hash, word count and overflow flag.
REQ-014 m_valid / m_ready  out / in  1 / 1  result handshake.

Function
REQ-015 The FSM SHALL have the states IDLE, FILL, STREAM, WAIT and RESULT.
REQ-016 IDLE: s_ready=1; an accepted byte SHALL move the FSM to FILL, or directly to STREAM if s_last is also high.
REQ-017 FILL: s_ready=1; byte k of the key SHALL be placed at word k/8, bits [8*(k%8)+7 : 8*(k%8)].
REQ-018 Unused bytes of the final word SHALL be zero.
REQ-019 Word count SHALL equal ceil(bytes/8), minimum 1.
REQ-020 Bytes beyond MAX_WORDS*8 SHALL be accepted and discarded, and sticky m_ovf SHALL be set for that key.
REQ-021 The FSM SHALL enter STREAM in the cycle after the s_last byte is accepted.
REQ-022 STREAM: s_ready=0; h_ce SHALL be high for exactly h_len consecutive cycles, starting in the first STREAM cycle.
REQ-023 STREAM: h_id SHALL carry words 0..len-1 in order; h_last SHALL be high only with the final word; for len=1 it is high in the single cycle.
REQ-024 After the final word the FSM SHALL enter WAIT with h_ce=0.
REQ-025 WAIT: an h_done pulse SHALL load m_hash from h_dout and move the FSM to RESULT.
REQ-026 An h_done received in any state other than WAIT SHALL be ignored.
REQ-027 RESULT: m_valid=1 and m_hash, m_words and m_ovf SHALL be held stable.
REQ-028 RESULT: m_valid&&m_ready SHALL return the FSM to IDLE in the next cycle.
REQ-029 s_ready SHALL be 0 in STREAM, WAIT and RESULT; no byte is accepted until IDLE.
REQ-030 h_id, h_last, h_ce and h_len SHALL be registered outputs.
REQ-031 Latency SHALL be 1 cycle from s_last acceptance to the first h_ce.

Reset
REQ-032 While rst_n=0, the FSM SHALL be in IDLE.
REQ-033 While rst_n=0, all outputs SHALL be 0 except s_ready=1.
REQ-034 While rst_n=0, byte and word counters and m_ovf SHALL be cleared.
REQ-035 Buffer contents need no reset; the zero-fill of REQ-018 SHALL guarantee padding.
REQ-036 Reset asserted mid-key or mid-stream SHALL abort the operation with no result produced.

Structure
REQ-037 Package jhash_pkg SHALL hold the FSM state enum, the MAX_WORDS and LEN_W defaults, and the 64-bit word type.
REQ-038 Sub-module jhash_byte_packer SHALL assemble bytes into zero-padded words and assert word-write strobes.
REQ-039 The top level SHALL contain the buffer (register array of MAX_WORDS x 64), the FSM and the stream counter.

Verification
REQ-040 "aaaabbbbcccc" (12 bytes) -> h_len=2; h_id=64'h62626262_61616161 then 64'h00000000_63636363; h_last on the 2nd; with the real core, m_hash=32'haae2d3d1, m_words=2.
REQ-041 512 bytes valued (i mod 256) -> 64 consecutive h_ce cycles; first h_id=64'h07060504_03020100; h_last on word 63; m_hash=32'hb79375ae, m_ovf=0.
REQ-042 1 byte 8'h5A with s_last -> single h_ce cycle with h_last=1, h_id=64'h5A, h_len=1, m_words=1.
REQ-043 513 bytes with MAX_WORDS=64 -> the 513th byte is accepted and dropped; h_len=64; m_ovf=1.
REQ-044 m_ready held 0 for 10 cycles in RESULT -> m_valid and m_hash stable and s_ready=0 throughout; a spurious h_done is ignored.
REQ-045 rst_n pulsed low during STREAM word 5 -> h_ce=0 immediately; no m_valid; the next key completes correctly.
